// File: rtl/lcd_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_timing_gen : RGB panel raster timing, one-cycle-ahead pixel requests   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lcd_timing_gen #(
    parameter int   H_SYNC   = 128,
    parameter int   H_BACK   = 88,
    parameter int   H_DISP   = 800,
    parameter int   H_FRONT  = 40,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_DISP   = 480,
    parameter int   V_FRONT  = 10,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic        disp_en,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam logic [10:0] c_h_total     = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT);
    localparam logic [10:0] c_v_total     = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT);
    localparam logic [10:0] c_h_sync      = 11'(H_SYNC);
    localparam logic [10:0] c_v_sync      = 11'(V_SYNC);
    localparam logic [10:0] c_h_act_start = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] c_h_act_end   = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] c_h_req_start = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] c_h_req_end   = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] c_v_act_start = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] c_v_act_end   = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] c_h_disp      = 11'(H_DISP);
    localparam logic [10:0] c_v_disp      = 11'(V_DISP);

    logic        r_run;
    logic        r_started;
    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        r_en_frame;
    logic [7:0]  r_frame_cnt;

    logic w_h_end;
    logic w_v_end;
    logic w_frame_end;
    logic w_first_run;
    logic w_h_act;
    logic w_h_req;
    logic w_v_act;
    logic w_de;

    assign w_h_end     = (r_h_cnt == c_h_total - 11'd1);
    assign w_v_end     = (r_v_cnt == c_v_total - 11'd1);
    assign w_frame_end = r_run && w_h_end && w_v_end;
    assign w_first_run = r_run && !r_started;
    assign w_h_act     = (r_h_cnt >= c_h_act_start) && (r_h_cnt < c_h_act_end);
    assign w_h_req     = (r_h_cnt >= c_h_req_start) && (r_h_cnt < c_h_req_end);
    assign w_v_act     = (r_v_cnt >= c_v_act_start) && (r_v_cnt < c_v_act_end);
    assign w_de        = r_run && r_en_frame && w_h_act && w_v_act;

    // Counters hold at origin during the first run cycle so frame_start lands there.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_started   <= 1'b0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_run     <= 1'b1;
            r_started <= r_run;
            if (r_run) begin
                if (w_h_end) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_end ? 11'd0 : r_v_cnt + 11'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 11'd1;
                end
            end
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Display enable only changes between frames so no partial frame is shown.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_frame <= 1'b0;
        end else if (w_first_run || w_frame_end) begin
            r_en_frame <= disp_en;
        end
    end

    always_comb begin
        lcd_hs      = ~SYNC_POL;
        lcd_vs      = ~SYNC_POL;
        pixel_xpos  = '0;
        pixel_ypos  = '0;
        frame_start = 1'b0;
        if (r_run) begin
            if (r_h_cnt < c_h_sync) lcd_hs = SYNC_POL;
            if (r_v_cnt < c_v_sync) lcd_vs = SYNC_POL;
            if (w_h_req && w_v_act) pixel_xpos = r_h_cnt - c_h_req_start;
            if (w_v_act)            pixel_ypos = r_v_cnt - c_v_act_start;
            frame_start = (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
        end
    end

    assign lcd_de    = w_de;
    assign lcd_rgb   = w_de ? pixel_data : 24'h0;
    assign frame_cnt = r_frame_cnt;
    assign h_disp    = c_h_disp;
    assign v_disp    = c_v_disp;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_lcd_timing_gen : small-raster bench with pixel scoreboard               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_lcd_timing_gen;

    // Raster: H 4+3+8+2 = 17, V 2+2+4+2 = 10, frame = 170 cycles.
    localparam int c_frame = 170;
    localparam int c_line  = 17;

    logic        lcd_pclk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        disp_en  = 1'b1;
    logic [23:0] pixel_data;
    logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
    logic        lcd_hs, lcd_vs, lcd_de, frame_start;
    logic [23:0] lcd_rgb;
    logic [7:0]  frame_cnt;
    logic [10:0] xpos_q;

    lcd_timing_gen #(
        .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(2),
        .SYNC_POL(1'b0)
    ) dut (
        .lcd_pclk   (lcd_pclk),
        .rst_n      (rst_n),
        .disp_en    (disp_en),
        .pixel_data (pixel_data),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .h_disp     (h_disp),
        .v_disp     (v_disp),
        .lcd_hs     (lcd_hs),
        .lcd_vs     (lcd_vs),
        .lcd_de     (lcd_de),
        .lcd_rgb    (lcd_rgb),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    // Composer model: returns the requested coordinate one cycle later.
    always @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) xpos_q <= '0;
        else        xpos_q <= pixel_xpos;
    end
    assign pixel_data = {xpos_q, pixel_ypos[7:0], 5'b0};

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [23:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every data-enable beat consumes one expected pixel.
    always @(negedge lcd_pclk) begin
        if (rst_n) begin
            if (lcd_de) begin
                if (sb_q.size() == 0) chk("de_unexpected", 32'(lcd_de), 32'd0);
                else                  chk("rgb", 32'(lcd_rgb), 32'(sb_q.pop_front()));
            end else begin
                chk("rgb_idle", 32'(lcd_rgb), 32'd0);
            end
        end
    end

    // Timing statistics, published per line / per frame on sync falling edges.
    logic prev_hs, prev_vs;
    int hs_lowcnt, hs_since, vs_lowcnt, vs_since, line_de;
    int a_de, a_lines, a_lmax, a_xnz, a_xmax, a_ynz, a_ymax;
    int r_hs_low, r_hs_per, r_vs_low, r_vs_per;
    int r_de, r_lines, r_lmax, r_xnz, r_xmax, r_ynz, r_ymax;
    int misalign = 0, fs_count = 0;

    always @(negedge lcd_pclk) begin
        if (!rst_n) begin
            prev_hs = 1'b1; prev_vs = 1'b1;
            hs_lowcnt = 0; hs_since = 0; vs_lowcnt = 0; vs_since = 0; line_de = 0;
            a_de = 0; a_lines = 0; a_lmax = 0; a_xnz = 0; a_xmax = 0; a_ynz = 0; a_ymax = 0;
            fs_count = 0;
        end else begin
            if (prev_hs && !lcd_hs) begin
                if (hs_since > 0) r_hs_per = hs_since;
                hs_since = 0;
                if (line_de > 0) begin
                    a_lines++;
                    if (line_de > a_lmax) a_lmax = line_de;
                end
                line_de = 0;
            end
            if (!prev_hs && lcd_hs) r_hs_low = hs_lowcnt;
            hs_lowcnt = lcd_hs ? 0 : hs_lowcnt + 1;
            hs_since++;
            if ((prev_vs != lcd_vs) && !(prev_hs && !lcd_hs)) misalign++;
            if (prev_vs && !lcd_vs) begin
                if (vs_since > 0) r_vs_per = vs_since;
                vs_since = 0;
                r_de = a_de; r_lines = a_lines; r_lmax = a_lmax;
                r_xnz = a_xnz; r_xmax = a_xmax; r_ynz = a_ynz; r_ymax = a_ymax;
                a_de = 0; a_lines = 0; a_lmax = 0; a_xnz = 0; a_xmax = 0; a_ynz = 0; a_ymax = 0;
            end
            if (!prev_vs && lcd_vs) r_vs_low = vs_lowcnt;
            vs_lowcnt = lcd_vs ? 0 : vs_lowcnt + 1;
            vs_since++;
            if (lcd_de) begin line_de++; a_de++; end
            if (pixel_xpos != 0) begin a_xnz++; if (int'(pixel_xpos) > a_xmax) a_xmax = int'(pixel_xpos); end
            if (pixel_ypos != 0) begin a_ynz++; if (int'(pixel_ypos) > a_ymax) a_ymax = int'(pixel_ypos); end
            if (frame_start) fs_count++;
            prev_hs = lcd_hs; prev_vs = lcd_vs;
        end
    end

    task automatic step();
        @(posedge lcd_pclk); #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) step();
    endtask

    task automatic push_frame();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                sb_q.push_back({11'(x), 8'(y), 5'b0});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hs"},  32'(lcd_hs), 32'd1);
        chk({tag, "_vs"},  32'(lcd_vs), 32'd1);
        chk({tag, "_de"},  32'(lcd_de), 32'd0);
        chk({tag, "_rgb"}, 32'(lcd_rgb), 32'd0);
        chk({tag, "_fs"},  32'(frame_start), 32'd0);
        chk({tag, "_xpos"}, 32'(pixel_xpos), 32'd0);
        chk({tag, "_ypos"}, 32'(pixel_ypos), 32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        disp_en = 1'b1;
        repeat (10) @(posedge lcd_pclk);
        #1;
        chk_reset_outputs("rst");
        chk("h_disp", 32'(h_disp), 32'd8);
        chk("v_disp", 32'(v_disp), 32'd4);

        @(negedge lcd_pclk);
        rst_n = 1'b1;
        @(posedge lcd_pclk); #1;
        cyc = 0;
        chk("fs_first_run", 32'(frame_start), 32'd1);
        chk("hs_origin", 32'(lcd_hs), 32'd0);
        chk("vs_origin", 32'(lcd_vs), 32'd0);

        for (int f = 0; f < 257; f++) begin
            if (f != 2) push_frame();
            if (f == 1) begin
                goto(c_frame + 5 * c_line + 3);
                disp_en = 1'b0;
            end
            if (f == 2) begin
                goto(2 * c_frame + 6 * c_line);
                disp_en = 1'b1;
            end
            goto(c_frame * (f + 1) + 1);
            chk($sformatf("de_total_f%0d", f), 32'(r_de), (f == 2) ? 32'd0 : 32'd32);
            chk($sformatf("frame_cnt_f%0d", f), 32'(frame_cnt), 32'((f + 1) % 256));
            if (f < 4) begin
                chk($sformatf("de_lines_f%0d", f), 32'(r_lines), (f == 2) ? 32'd0 : 32'd4);
                chk($sformatf("de_per_line_f%0d", f), 32'(r_lmax), (f == 2) ? 32'd0 : 32'd8);
                chk($sformatf("xpos_steps_f%0d", f), 32'(r_xnz), 32'd28);
                chk($sformatf("xpos_max_f%0d", f), 32'(r_xmax), 32'd7);
                chk($sformatf("ypos_nz_f%0d", f), 32'(r_ynz), 32'd51);
                chk($sformatf("ypos_max_f%0d", f), 32'(r_ymax), 32'd3);
                chk($sformatf("hs_low_f%0d", f), 32'(r_hs_low), 32'd4);
                chk($sformatf("hs_period_f%0d", f), 32'(r_hs_per), 32'd17);
                chk($sformatf("vs_low_f%0d", f), 32'(r_vs_low), 32'd34);
                chk($sformatf("vs_period_f%0d", f), 32'(r_vs_per), 32'd170);
            end
        end
        chk("fs_count", 32'(fs_count), 32'd258);
        chk("vs_hs_align", 32'(misalign), 32'd0);

        // Reset mid-line while pixels are being driven.
        push_frame();
        goto(257 * c_frame + 5 * c_line + 10);
        chk("sb_pending", 32'(sb_q.size()), 32'd21);
        chk("de_before_rst", 32'(lcd_de), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        sb_q.delete();
        repeat (3) @(posedge lcd_pclk);
        @(negedge lcd_pclk);
        rst_n = 1'b1;
        @(posedge lcd_pclk); #1;
        chk("fs_restart", 32'(frame_start), 32'd1);
        chk("hs_restart", 32'(lcd_hs), 32'd0);
        chk("fcnt_restart", 32'(frame_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Generates the LCD raster timing for the RGB panel. It produces the hsync, vsync and data-enable signals. It also produces a pixel request coordinate (`pixel_xpos`/`pixel_ypos`) that runs one cycle ahead of the data enable. The display pipeline (the image/morphology composer) consumes this coordinate and returns `pixel_data` one cycle later. This block gates that data onto `lcd_rgb` aligned with `lcd_de`.

## Interface
Parameters:
- `H_SYNC`, 128, hsync pulse width (pclk)
- `H_BACK`, 88, horizontal back porch
- `H_DISP`, 800, active pixels per line (≤ 2047)
- `H_FRONT`, 40, horizontal front porch
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch
- `V_DISP`, 480, active lines (≤ 2047)
- `V_FRONT`, 10, vertical front porch
- `SYNC_POL`, 1'b0, active level of `lcd_hs`/`lcd_vs`
- Derived: `H_TOTAL` = sum of the four H parameters (1056); `V_TOTAL` = sum of the four V parameters (525).

Ports:
- `lcd_pclk`  in  1  pixel clock
- `rst_n`  in  1  reset, asynchronous, active-low; clock `lcd_pclk`
- `disp_en`  in  1  display enable, sampled at frame boundary
- `pixel_data`  in  24  RGB888 from composer, valid one cycle after request
- `pixel_xpos`  out  11  requested column, 0..H_DISP-1
- `pixel_ypos`  out  11  requested row, 0..V_DISP-1
- `h_disp`  out  11  constant H_DISP
- `v_disp`  out  11  constant V_DISP
- `lcd_hs`  out  1  horizontal sync
- `lcd_vs`  out  1  vertical sync
- `lcd_de`  out  1  data enable
- `lcd_rgb`  out  24  panel pixel bus
- `frame_start`  out  1  one-cycle pulse at raster origin
- `frame_cnt`  out  8  completed-frame counter, wraps

## Operation
- `run` flag: 0 in reset, 1 on the first clock edge after reset release.
- While `run`=0:
  - `h_cnt`, `v_cnt`, `frame_cnt` = 0
  - `lcd_hs`/`lcd_vs` = ~SYNC_POL
  - `lcd_de`, `frame_start`, `pixel_xpos`, `pixel_ypos`, `lcd_rgb` = 0
- Counters:
  - `h_cnt` 0..H_TOTAL-1, wraps to 0.
  - `v_cnt` increments when `h_cnt`=H_TOTAL-1 and wraps after V_TOTAL-1.
  - Both are 11-bit registers.
- Syncs:
  - `lcd_hs` = SYNC_POL when `h_cnt` < H_SYNC.
  - `lcd_vs` = SYNC_POL when `v_cnt` < V_SYNC.
  - Both are decoded from the registered counters.
- Active window: H_ACT = [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP); V_ACT = [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
- `lcd_de` is high iff `h_cnt` ∈ H_ACT, `v_cnt` ∈ V_ACT and `en_frame`=1.
- Request window: `h_cnt` ∈ [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_DISP-1) and `v_cnt` ∈ V_ACT.
  - Inside the window: `pixel_xpos` = `h_cnt`-(H_SYNC+H_BACK-1); otherwise 0.
- `pixel_ypos` = `v_cnt`-(V_SYNC+V_BACK) inside V_ACT, otherwise 0. Blanking lines therefore present `ypos`=0 to the composer, which uses them for line-buffer pre-fill.
- Request coordinates are produced independently of `en_frame`, so the composer pipeline keeps running.
- `lcd_rgb` = `lcd_de` ? `pixel_data` : 24'h0.
- `en_frame`:
  - Register, 0 in reset.
  - Loads `disp_en` when `h_cnt`=H_TOTAL-1 and `v_cnt`=V_TOTAL-1, and on the first `run` cycle.
  - A `disp_en` change mid-frame never produces a partial frame.
- `frame_start` = 1 for exactly the cycle with `h_cnt`=0, `v_cnt`=0, `run`=1.
- `frame_cnt` increments (mod 256) on the same edge on which `v_cnt` wraps from V_TOTAL-1 to 0.
- Reset asserted mid-frame: all outputs return to reset values asynchronously, and the raster restarts at origin after release.

## Timing
- Request-to-enable latency is exactly 1 cycle: `pixel_xpos`=k at cycle t implies `lcd_de`=1 at t+1 with `lcd_rgb` = `pixel_data`(t+1).
- First request cycle of a line: `h_cnt`=215 (defaults). `lcd_de` rises at `h_cnt`=216 and falls after `h_cnt`=1015.
- Line period: H_TOTAL cycles. Frame period: H_TOTAL×V_TOTAL = 554400 cycles (defaults).
- First `frame_start` occurs on the first `run` cycle.
- `lcd_hs`/`lcd_vs` are not skewed relative to each other; `lcd_vs` edges coincide with `h_cnt`=0.

## Test plan
- **Reset:** hold `rst_n`=0 for 10 cycles.
  - During reset: `lcd_hs`=`lcd_vs`=1, `lcd_de`=0, `lcd_rgb`=0, `frame_cnt`=0.
  - After release: `frame_start` pulses on the first `run` cycle.
  - Assert reset mid-line at `h_cnt`=500: all outputs return to reset values immediately.
- **Horizontal timing:** measure the `lcd_hs` low width (128 cycles) and period (1056 cycles). Count `lcd_de` high cycles per active line: exactly 800.
- **Coordinate alignment:** drive `pixel_data` = {`xpos` registered one cycle, `ypos`[7:0], 5'b0}.
  - First `lcd_de` cycle of row 0 shows `xpos`=0; last shows 799.
  - `lcd_rgb`=0 whenever `lcd_de`=0.
- **Vertical timing:**
  - `lcd_vs` low for 2×1056 cycles; period 554400.
  - `pixel_ypos` runs 0..479 across active lines and is 0 in blanking.
  - No `lcd_de` on the 45 blanking lines.
- **disp_en:** drop `disp_en` at row 100.
  - The current frame completes with 480 active lines.
  - The next frame has `lcd_de`=0 throughout, with `pixel_xpos` still stepping.
  - Re-raise `disp_en` mid-frame: output resumes only on the following frame.
- **Frame counter:** run 257 frames. `frame_cnt` wraps 255→0 and reads 1. `frame_start` count equals 257, plus 1 for the first pulse.
